// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-read-port register file for the datapath. It sits between decode
//   (reads, busy-set) and writeback (write, busy-clear).
//     - NREAD combinational read ports, one synchronous write port.
//     - Register 0 is hardwired to zero. Writes to it are dropped.
//     - Optional same-cycle write-to-read bypass (BYPASS).
//     - Per-register busy scoreboard for multi-cycle producers, plus a
//       registered count of busy registers, so decode can stall on RAW hazards.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   rd_addr_i    in   NREAD*ADDR_W  read addresses, port p = [p*ADDR_W +: ADDR_W]
//   rd_data_o    out  NREAD*DATA_W  read data,      port p = [p*DATA_W +: DATA_W]
//   rd_busy_o    out  NREAD         port p's register awaits a pending write
//   wr_en_i      in   write strobe from writeback
//   wr_addr_i    in   write address
//   wr_data_i    in   write data
//   bset_en_i    in   mark bset_addr_i busy (producer issued)
//   bset_addr_i  in   register to mark busy
//   busy_cnt_o   out  number of registers currently busy
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr_i,
    output logic [NREAD*DATA_W-1:0]   rd_data_o,
    output logic [NREAD-1:0]          rd_busy_o,
    input  logic                      wr_en_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      bset_en_i,
    input  logic [ADDR_W-1:0]         bset_addr_i,
    output logic [ADDR_W:0]           busy_cnt_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // -----------------------------------------------------------------------
    // Qualified strobes. Address 0 never takes part in writes or busy-sets,
    // and addresses are never looked at while their enable is low.
    // -----------------------------------------------------------------------
    logic wr_valid;
    logic set_valid;

    assign wr_valid  = wr_en_i   && (wr_addr_i   != '0);
    assign set_valid = bset_en_i && (bset_addr_i != '0);

    // -----------------------------------------------------------------------
    // Storage. Entry 0 is reset to zero and never written, so it folds to a
    // constant. The read path also forces zero for address 0.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_valid) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Busy scoreboard
    // -----------------------------------------------------------------------
    logic [Depth-1:0] busy_q;
    logic [Depth-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wr_valid) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        // The set is applied after the clear: a new producer issued in the
        // same cycle as the old one's writeback keeps the register busy.
        if (set_valid) begin
            busy_d[bset_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Busy count, kept incrementally so it matches the popcount of busy_q
    // without a wide adder tree. A set only counts if the bit was clear. A
    // clear only counts if the bit was set and is not re-set in this cycle.
    // -----------------------------------------------------------------------
    logic [ADDR_W:0] cnt_q;
    logic [ADDR_W:0] cnt_d;
    logic            cnt_inc;
    logic            cnt_dec;
    logic            same_addr;

    assign same_addr = set_valid && wr_valid && (bset_addr_i == wr_addr_i);
    assign cnt_inc   = set_valid && !busy_q[bset_addr_i];
    assign cnt_dec   = wr_valid && busy_q[wr_addr_i] && !same_addr;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + (ADDR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (ADDR_W + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_cnt_o = cnt_q;

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              fwd;
        logic [DATA_W-1:0] data;

        assign ra = rd_addr_i[p*ADDR_W +: ADDR_W];

        // Forward the writeback value in the cycle it is written. A pending
        // write to the register also resolves its busy state for this read.
        assign fwd = (BYPASS != 0) && wr_valid && (wr_addr_i == ra);

        always_comb begin
            if (ra == '0) begin
                data = '0;
            end else if (fwd) begin
                data = wr_data_i;
            end else begin
                data = mem_q[ra];
            end
        end

        assign rd_data_o[p*DATA_W +: DATA_W] = data;
        assign rd_busy_o[p]                  = (ra != '0) && busy_q[ra] && !fwd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp. Two instances share the same stimulus: one with
// bypass enabled and one without. A behavioural model (arrays of register
// values and busy flags) is compared on every falling edge. Directed sections
// pin the expected behaviour with literal values.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic             clk;
    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             bset_en;
    logic [AW-1:0]    bset_addr;

    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic [AW:0]      cnt_b, cnt_n;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(1)) u_dut_byp (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_b),
        .rd_busy_o  (rd_busy_b),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .bset_en_i  (bset_en),
        .bset_addr_i(bset_addr),
        .busy_cnt_o (cnt_b)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(0)) u_dut_nob (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_n),
        .rd_busy_o  (rd_busy_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .bset_en_i  (bset_en),
        .bset_addr_i(bset_addr),
        .busy_cnt_o (cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] reg_m  [32];
    bit            busy_m [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                reg_m[i]  = '0;
                busy_m[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                reg_m[wr_addr]  = wr_data;
                busy_m[wr_addr] = 1'b0;
            end
            if (bset_en && bset_addr != 0) busy_m[bset_addr] = 1'b1;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int            nbusy;
        logic [AW-1:0] a;
        logic [DW-1:0] exp_d;
        bit            hit;
        if (cmp_en && rst_n) begin
            nbusy = 0;
            for (int i = 0; i < 32; i++) nbusy += int'(busy_m[i]);
            chk("cnt_byp", 64'(cnt_b), 64'(nbusy));
            chk("cnt_nob", 64'(cnt_n), 64'(nbusy));
            for (int p = 0; p < NR; p++) begin
                a   = rd_addr[p*AW +: AW];
                hit = wr_en && (wr_addr == a);
                exp_d = (a == 0) ? '0 : (hit ? wr_data : reg_m[a]);
                chk("rd_data_byp", 64'(rd_data_b[p*DW +: DW]), 64'(exp_d));
                chk("rd_busy_byp", 64'(rd_busy_b[p]), 64'((a != 0) && busy_m[a] && !hit));
                exp_d = (a == 0) ? '0 : reg_m[a];
                chk("rd_data_nob", 64'(rd_data_n[p*DW +: DW]), 64'(exp_d));
                chk("rd_busy_nob", 64'(rd_busy_n[p]), 64'((a != 0) && busy_m[a]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        bset_en = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic do_set(input logic [AW-1:0] a);
        bset_en = 1'b1; bset_addr = a;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0; bset_en = 0; bset_addr = '0;
        step(); step();
        set_rd(5, 7);
        #1;
        chk("reset_cnt", 64'(cnt_b), 64'd0);
        chk("reset_rd", 64'(rd_data_b), 64'd0);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        step();

        // Write/read, r0 hardwired
        do_wr(5, 32'hDEADBEEF);
        step(); idle(); set_rd(5, 5); #1;
        chk("wr_r5_p0", 64'(rd_data_b[31:0]),  64'hDEADBEEF);
        chk("wr_r5_p1", 64'(rd_data_b[63:32]), 64'hDEADBEEF);
        chk("wr_r5_nob", 64'(rd_data_n), {32'hDEADBEEF, 32'hDEADBEEF});
        do_wr(0, 32'h1234); set_rd(0, 0); #1;
        chk("wr_r0_byp_same", 64'(rd_data_b), 64'd0);
        step(); idle(); #1;
        chk("wr_r0_after", 64'(rd_data_b), 64'd0);

        // Bypass vs no bypass
        do_wr(7, 32'h11);
        step(); do_wr(7, 32'hA5A5A5A5); set_rd(0, 7); #1;
        chk("byp_p1", 64'(rd_data_b[63:32]), 64'hA5A5A5A5);
        chk("nob_old", 64'(rd_data_n[63:32]), 64'h11);
        step(); idle(); #1;
        chk("nob_new", 64'(rd_data_n[63:32]), 64'hA5A5A5A5);

        // Scoreboard set / clear
        do_set(3);
        step(); idle(); set_rd(3, 0); #1;
        chk("sb_busy", 64'(rd_busy_b[0]), 64'd1);
        chk("sb_cnt1", 64'(cnt_b), 64'd1);
        do_wr(3, 32'd9); #1;
        chk("sb_byp_clr", 64'(rd_busy_b[0]), 64'd0);
        chk("sb_nob_busy", 64'(rd_busy_n[0]), 64'd1);
        chk("sb_byp_data", 64'(rd_data_b[31:0]), 64'd9);
        step(); idle(); #1;
        chk("sb_cnt0", 64'(cnt_b), 64'd0);
        chk("sb_cnt0_nob", 64'(cnt_n), 64'd0);

        // Set/clear collision on the same register
        do_set(4);
        step(); do_set(4); do_wr(4, 32'd1); set_rd(4, 4);
        step(); idle(); #1;
        chk("col_busy", 64'(rd_busy_b[0]), 64'd1);
        chk("col_cnt", 64'(cnt_b), 64'd1);
        chk("col_data", 64'(rd_data_n[31:0]), 64'd1);
        do_wr(4, 32'd2);
        step(); idle(); do_set(0);
        step(); idle(); #1;
        chk("bset_r0_cnt", 64'(cnt_b), 64'd0);

        // Fill and drain
        for (int i = 1; i < 32; i++) begin
            do_set(AW'(i));
            step();
        end
        idle(); #1;
        chk("fill_cnt", 64'(cnt_b), 64'd31);
        chk("fill_cnt_nob", 64'(cnt_n), 64'd31);
        for (int i = 1; i < 32; i++) begin
            do_wr(AW'(i), DW'(i * 3));
            step();
        end
        idle(); #1;
        chk("drain_cnt", 64'(cnt_b), 64'd0);

        // Randomised traffic, concentrated on a few registers for collisions
        for (int n = 0; n < 1500; n++) begin
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_data   = $urandom;
            bset_en   = ($urandom_range(0, 2) != 0);
            bset_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rd_addr   = NR*AW'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
            step();
        end

        // Asynchronous reset in the middle of a run
        idle(); do_wr(9, 32'hCAFE); do_set(10);
        step(); idle(); set_rd(9, 10); #1;
        chk("pre_rst_data", 64'(rd_data_b[31:0]), 64'hCAFE);
        chk("pre_rst_busy", 64'(rd_busy_b[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data", 64'(rd_data_b), 64'd0);
        chk("rst_data_nob", 64'(rd_data_n), 64'd0);
        chk("rst_busy", 64'({rd_busy_b, rd_busy_n}), 64'd0);
        chk("rst_cnt", 64'({cnt_b, cnt_n}), 64'd0);
        // Writes and sets while held in reset must be ignored
        do_wr(9, 32'h55); do_set(9); set_rd(1, 2);
        step(); step();
        idle(); set_rd(9, 9);
        #2 rst_n = 1'b1;
        #1;
        chk("post_rst_data", 64'(rd_data_b), 64'd0);
        chk("post_rst_cnt", 64'(cnt_b), 64'd0);
        step(); step();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
